// File: rtl/tdm_mux_8_1_if.sv
// tdm_mux_8_1 bus: eight channel inputs with per-channel
// valid/ready, plus the shared slot output stream.
interface tdm_mux_8_1_if #(
  parameter int WIDTH  = 1,
  parameter int FCNT_W = 8
);
  logic [7:0]         ch_en;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_valid;
  logic [7:0]         in_ready;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_valid;
  logic               out_sof;
  logic [FCNT_W-1:0]  frame_cnt;

  modport master (
    output ch_en, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel,
    input  out_valid, out_sof, frame_cnt
  );

  modport slave (
    input  ch_en, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel,
    output out_valid, out_sof, frame_cnt
  );
endinterface

// File: rtl/tdm_mux_8_1.sv
// Eight-channel round-robin TDM multiplexer with
// one-entry holding buffer per channel.
module tdm_mux_8_1 #(
  parameter int WIDTH  = 1,
  parameter int FCNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  tdm_mux_8_1_if.slave bus
);
  logic [2:0]        slot_q, slot_d;
  logic [7:0]        full_q, full_d;
  logic [WIDTH-1:0]  hold_q [8];
  logic [WIDTH-1:0]  hold_d [8];
  logic [7:0]        unload, rdy, load;
  logic [WIDTH-1:0]  odata_q, odata_d;
  logic [2:0]        osel_q;
  logic              ovalid_q, osof_q;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    unload = '0;
    if (bus.out_ready) unload[slot_q] = 1'b1;
    rdy  = bus.ch_en & (~full_q | unload);
    load = bus.in_valid & rdy;
    for (int i = 0; i < 8; i++) begin
      full_d[i] = load[i] | (full_q[i] & ~unload[i]);
      hold_d[i] = load[i] ? bus.in_data[i*WIDTH +: WIDTH]
                          : hold_q[i];
    end
    slot_d  = slot_q + 3'd1;
    odata_d = full_q[slot_q] ? hold_q[slot_q] : '0;
    fcnt_d  = (slot_q == 3'd7) ? fcnt_q + 1'b1 : fcnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= '0;
      full_q   <= '0;
      for (int i = 0; i < 8; i++) hold_q[i] <= '0;
      odata_q  <= '0;
      osel_q   <= '0;
      ovalid_q <= 1'b0;
      osof_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      full_q <= full_d;
      for (int i = 0; i < 8; i++) hold_q[i] <= hold_d[i];
      // the output stage reads the pre-load word, so an
      // unload paired with a reload keeps both words
      if (bus.out_ready) begin
        slot_q   <= slot_d;
        osel_q   <= slot_q;
        ovalid_q <= full_q[slot_q];
        odata_q  <= odata_d;
        osof_q   <= (slot_q == 3'd0);
        fcnt_q   <= fcnt_d;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = odata_q;
  assign bus.out_sel   = osel_q;
  assign bus.out_valid = ovalid_q;
  assign bus.out_sof   = osof_q;
  assign bus.frame_cnt = fcnt_q;
endmodule

// File: tb/tb_tdm_mux_8_1.sv
// Directed bench for tdm_mux_8_1: cycle table plus
// hand sequences for streaming, stall, enable and reset.
module tb_tdm_mux_8_1;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tdm_mux_8_1_if #(.WIDTH(4), .FCNT_W(8)) bus ();

  tdm_mux_8_1 #(.WIDTH(4), .FCNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  en;
    logic [7:0]  vld;
    logic [31:0] dat;
    logic        ordy;
    logic [7:0]  rdy;
    logic        v;
    logic [2:0]  sel;
    logic [3:0]  d;
    logic        sof;
    logic [7:0]  fc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] en,
                       input logic [7:0] vld,
                       input logic [31:0] dat,
                       input logic ordy);
    bus.ch_en     = en;
    bus.in_valid  = vld;
    bus.in_data   = dat;
    bus.out_ready = ordy;
  endtask

  task automatic add(input logic [7:0] en,
                     input logic [7:0] vld,
                     input logic [31:0] dat,
                     input logic ordy,
                     input logic [7:0] rdy,
                     input logic v,
                     input logic [2:0] sel,
                     input logic [3:0] d,
                     input logic sof,
                     input logic [7:0] fc);
    vec_t e;
    e.en = en; e.vld = vld; e.dat = dat; e.ordy = ordy;
    e.rdy = rdy; e.v = v; e.sel = sel; e.d = d;
    e.sof = sof; e.fc = fc;
    tbl.push_back(e);
  endtask

  task automatic chk_out(input string nm,
                         input logic v,
                         input logic [2:0] sel,
                         input logic [3:0] d,
                         input logic sof,
                         input logic [7:0] fc);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({nm, ".sel"}, 32'(bus.out_sel), 32'(sel));
    chk({nm, ".data"}, 32'(bus.out_data), 32'(d));
    chk({nm, ".sof"}, 32'(bus.out_sof), 32'(sof));
    chk({nm, ".fcnt"}, 32'(bus.frame_cnt), 32'(fc));
  endtask

  initial begin
    int d3;
    logic [2:0] s;
    logic [3:0] w;

    // idle run: two frames, nothing loaded
    for (int k = 0; k < 16; k++)
      add(8'hFF, 8'h00, 0, 1, 8'hFF, 0, 3'(k % 8), 0,
          (k % 8) == 0, 8'((k + 1) / 8));
    // ch2 and ch5 loaded together in slot 0
    add(8'hFF, 8'h24, 32'h0010_0100, 1, 8'hFF, 0, 0, 0, 1, 2);
    add(8'hFF, 8'h00, 0, 1, 8'hDB, 0, 1, 0, 0, 2);
    add(8'hFF, 8'h00, 0, 1, 8'hDF, 1, 2, 1, 0, 2);
    add(8'hFF, 8'h00, 0, 1, 8'hDF, 0, 3, 0, 0, 2);
    add(8'hFF, 8'h00, 0, 1, 8'hDF, 0, 4, 0, 0, 2);
    add(8'hFF, 8'h00, 0, 1, 8'hFF, 1, 5, 1, 0, 2);
    add(8'hFF, 8'h00, 0, 1, 8'hFF, 0, 6, 0, 0, 2);
    add(8'hFF, 8'h00, 0, 1, 8'hFF, 0, 7, 0, 0, 3);

    rst = 1'b1;
    drive(8'hFF, 8'h00, 0, 1'b1);
    #3;
    chk_out("reset", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;

    foreach (tbl[j]) begin
      drive(tbl[j].en, tbl[j].vld, tbl[j].dat, tbl[j].ordy);
      #2;
      chk($sformatf("tbl%0d.in_ready", j),
          32'(bus.in_ready), 32'(tbl[j].rdy));
      tick();
      chk_out($sformatf("tbl%0d", j), tbl[j].v, tbl[j].sel,
              tbl[j].d, tbl[j].sof, tbl[j].fc);
    end

    // ch3 streaming: one word per frame, then drain
    d3 = 0;
    for (int k = 0; k < 32; k++) begin
      logic er;
      er = (k == 0) || (k % 8 == 3) || (k > 27);
      drive(8'hFF, (k < 24) ? 8'h08 : 8'h00,
            32'(d3) << 12, 1'b1);
      #2;
      chk($sformatf("str%0d.rdy3", k),
          32'(bus.in_ready[3]), 32'(er));
      tick();
      if ((k < 24) && er) d3++;
      s = 3'(k % 8);
      if (s == 3'd3)
        chk($sformatf("str%0d.data", k),
            32'(bus.out_data), 32'(k / 8));
      chk($sformatf("str%0d.valid", k),
          32'(bus.out_valid), 32'(s == 3'd3));
      chk($sformatf("str%0d.sel", k), 32'(bus.out_sel), 32'(s));
    end
    chk("str.fcnt", 32'(bus.frame_cnt), 7);

    // stall at slot 4 with ch4 full
    drive(8'hFF, 8'h10, 32'hA << 16, 1'b1);
    tick();
    drive(8'hFF, 8'h00, 0, 1'b1);
    repeat (3) tick();
    drive(8'hFF, 8'h50, (32'h5 << 16) | (32'h6 << 24), 1'b0);
    #2;
    chk("stall.in_ready", 32'(bus.in_ready), 32'hEF);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d.rdy4", k),
          32'(bus.in_ready[4]), 0);
      chk_out($sformatf("stall%0d", k), 0, 3, 0, 0, 7);
    end
    drive(8'hFF, 8'h00, 0, 1'b1);
    tick(); chk_out("rel4", 1, 4, 4'hA, 0, 7);
    tick(); chk_out("rel5", 0, 5, 0, 0, 7);
    tick(); chk_out("rel6", 1, 6, 4'h6, 0, 7);
    tick(); chk_out("rel7", 0, 7, 0, 0, 8);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("nodup%0d.valid", k), 32'(bus.out_valid), 0);
    end
    chk("nodup.fcnt", 32'(bus.frame_cnt), 9);

    // ch0 disabled, everything else always offering
    drive(8'hFE, 8'hFF, 32'h7654_3210, 1'b1);
    for (int k = 0; k < 24; k++) begin
      #2;
      if (k == 0)
        chk("en.in_ready", 32'(bus.in_ready), 32'hFE);
      chk($sformatf("en%0d.rdy0", k), 32'(bus.in_ready[0]), 0);
      tick();
      s = 3'(k % 8);
      w = (s != 3'd0) ? 4'(s) : 4'd0;
      chk($sformatf("en%0d.valid", k),
          32'(bus.out_valid), 32'(s != 3'd0));
      chk($sformatf("en%0d.data", k), 32'(bus.out_data), 32'(w));
    end
    chk("en.fcnt", 32'(bus.frame_cnt), 12);

    // reset mid-frame with ch3..ch7 still full
    drive(8'hFF, 8'h00, 0, 1'b1);
    tick(); chk_out("pre0", 0, 0, 0, 1, 12);
    tick(); chk_out("pre1", 1, 1, 1, 0, 12);
    tick(); chk_out("pre2", 1, 2, 2, 0, 12);
    #2;
    rst = 1'b1;
    #1;
    chk_out("arst", 0, 0, 0, 0, 0);
    chk("arst.in_ready", 32'(bus.in_ready), 32'hFF);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out($sformatf("post%0d", k), 0, 3'(k), 0, k == 0,
              (k == 7) ? 8'd1 : 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
